// File: rtl/cmp_arbiter.sv
// Round-robin arbiter that shares one pipelined comparator between NREQ requesters.
// Requester tags travel beside the comparator latency and steer each result to its owner.
module cmp_arbiter #(
  parameter int WIDTH = 65,
  parameter int NREQ  = 4,
  parameter int LAT   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*(WIDTH+1)-1:0]   a_in,
  input  logic [NREQ*(WIDTH+1)-1:0]   b_in,
  input  logic                        en,
  output logic [NREQ-1:0]             gnt,
  output logic [WIDTH:0]              cmp_a,
  output logic [WIDTH:0]              cmp_b,
  output logic                        cmp_vld,
  input  logic                        cmp_gt,
  output logic [NREQ-1:0]             res_valid,
  output logic                        res_gt,
  output logic [3:0]                  inflight,
  output logic                        busy
);

  localparam int W  = WIDTH + 1;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] LSB1 = NREQ'(1);

  typedef logic [IW-1:0] idx_t;

  idx_t            ptr_q, ptr_d;
  idx_t            gnt_idx, cand;
  logic            found, issue;
  logic [W-1:0]    sel_a, sel_b;
  logic [W-1:0]    cmp_a_q, cmp_b_q;
  logic [LAT:0]    tv_q;
  idx_t            tag_q [0:LAT];
  logic [NREQ-1:0] res_valid_q;
  logic            res_gt_q;
  logic [3:0]      inflight_q, inflight_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = idx_t'((int'(ptr_q) + k) % NREQ);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    issue = found && en && rst;

    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == idx_t'(i)) begin
        sel_a = a_in[i*W +: W];
        sel_b = b_in[i*W +: W];
      end
    end

    ptr_d = issue ? idx_t'((int'(gnt_idx) + 1) % NREQ) : ptr_q;

    // A grant and a retiring result in the same cycle cancel out.
    unique case ({issue, |res_valid_q})
      2'b10:   inflight_d = inflight_q + 4'd1;
      2'b01:   inflight_d = inflight_q - 4'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
      tv_q        <= '0;
      res_valid_q <= '0;
      res_gt_q    <= 1'b0;
      inflight_q  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values and the valid shift reads old stages.
      ptr_q      <= ptr_d;
      tv_q       <= {tv_q[LAT-1:0], issue};
      inflight_q <= inflight_d;
      if (issue) begin
        cmp_a_q <= sel_a;
        cmp_b_q <= sel_b;
      end
      res_valid_q <= tv_q[LAT] ? (LSB1 << tag_q[LAT]) : '0;
      if (tv_q[LAT]) begin
        res_gt_q <= cmp_gt;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the tag array is left unreset; each entry is only used when its reset valid bit is set.
    tag_q[0] <= gnt_idx;
    for (int s = 1; s <= LAT; s++) begin
      tag_q[s] <= tag_q[s-1];
    end
  end

  assign gnt       = issue ? (LSB1 << gnt_idx) : '0;
  assign cmp_a     = cmp_a_q;
  assign cmp_b     = cmp_b_q;
  assign cmp_vld   = tv_q[0];
  assign res_valid = res_valid_q;
  assign res_gt    = res_gt_q;
  assign inflight  = inflight_q;
  assign busy      = |inflight_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: a LAT-deep comparator model closes the loop and each
// scenario task checks grants, issue, result routing and occupancy against hand-computed values.
module tb_cmp_arbiter;

  localparam int WIDTH = 65;
  localparam int NREQ  = 4;
  localparam int LAT   = 4;
  localparam int W     = WIDTH + 1;

  logic              clk, rst, en, cmp_gt, cmp_vld, res_gt, busy;
  logic [NREQ-1:0]   req, gnt, res_valid;
  logic [NREQ*W-1:0] a_in, b_in;
  logic [W-1:0]      cmp_a, cmp_b;
  logic [3:0]        inflight;

  int n_checks = 0;
  int n_errors = 0;

  cmp_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .en(en),
    .gnt(gnt), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_vld(cmp_vld), .cmp_gt(cmp_gt),
    .res_valid(res_valid), .res_gt(res_gt), .inflight(inflight), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator model: A > B on positive normal operands, LAT cycles after presentation.
  logic [LAT-1:0] gt_pipe = '0;
  always @(posedge clk) gt_pipe <= {gt_pipe[LAT-2:0], (cmp_a > cmp_b)};
  assign cmp_gt = gt_pipe[LAT-1];

  function automatic logic [W-1:0] fp(input int e, input logic [51:0] m);
    return {2'b01, 1'b0, e[10:0], m};
  endfunction

  logic [W-1:0] one_v, two_v, three_v;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    en  = 1'b1;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; req = 4'hF; a_in = '0; b_in = '0;
    tick(); tick();
    n_checks++; if (gnt !== 4'h0) begin n_errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    n_checks++; if (cmp_vld !== 1'b0) begin n_errors++; $display("FAIL reset_cmp_vld: got %b expected 0", cmp_vld); end
    n_checks++; if (res_valid !== 4'h0) begin n_errors++; $display("FAIL reset_res_valid: got %b expected 0000", res_valid); end
    n_checks++; if (inflight !== 4'd0 || busy !== 1'b0) begin n_errors++; $display("FAIL reset_inflight: got %0d/%b expected 0/0", inflight, busy); end
    n_checks++; if (cmp_a !== '0 || cmp_b !== '0) begin n_errors++; $display("FAIL reset_cmp_ab: got %h/%h expected 0/0", cmp_a, cmp_b); end
    req = '0;
    rst = 1'b1;
  endtask

  task automatic test_single();
    set_op(0, two_v, one_v);
    for (int c = 0; c <= 8; c++) begin
      req = (c == 0) ? 4'b0001 : 4'b0000;
      #1;
      n_checks++; if (gnt !== ((c == 0) ? 4'b0001 : 4'b0000)) begin n_errors++; $display("FAIL single_gnt c=%0d: got %b", c, gnt); end
      n_checks++; if (cmp_vld !== (c == 1)) begin n_errors++; $display("FAIL single_cmp_vld c=%0d: got %b expected %b", c, cmp_vld, (c == 1)); end
      n_checks++; if (res_valid !== ((c == 6) ? 4'b0001 : 4'b0000)) begin n_errors++; $display("FAIL single_res_valid c=%0d: got %b", c, res_valid); end
      n_checks++; if (inflight !== ((c >= 1 && c <= 6) ? 4'd1 : 4'd0)) begin n_errors++; $display("FAIL single_inflight c=%0d: got %0d", c, inflight); end
      if (c == 1) begin
        n_checks++; if (cmp_a !== two_v || cmp_b !== one_v) begin n_errors++; $display("FAIL single_cmp_ab: got %h/%h expected %h/%h", cmp_a, cmp_b, two_v, one_v); end
      end
      if (c >= 6) begin
        n_checks++; if (res_gt !== 1'b1) begin n_errors++; $display("FAIL single_res_gt c=%0d: got %b expected 1", c, res_gt); end
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g, exp_rv;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, fp(1023 + i, 52'h0), two_v);
    for (int c = 0; c <= 14; c++) begin
      req = (c < 8) ? 4'hF : 4'h0;
      #1;
      exp_g  = (c < 8) ? 4'(1 << (c % 4)) : 4'h0;
      exp_rv = (c >= 6 && c <= 13) ? 4'(1 << ((c - 6) % 4)) : 4'h0;
      n_checks++; if (gnt !== exp_g) begin n_errors++; $display("FAIL rr_gnt c=%0d: got %b expected %b", c, gnt, exp_g); end
      n_checks++; if (res_valid !== exp_rv) begin n_errors++; $display("FAIL rr_res_valid c=%0d: got %b expected %b", c, res_valid, exp_rv); end
      if (exp_rv != 4'h0) begin
        n_checks++; if (res_gt !== (((c - 6) % 4) >= 2)) begin n_errors++; $display("FAIL rr_res_gt c=%0d: got %b", c, res_gt); end
      end
      if (c == 6) begin
        n_checks++; if (inflight !== 4'd6 || busy !== 1'b1) begin n_errors++; $display("FAIL rr_inflight_peak: got %0d expected 6", inflight); end
      end
      if (c == 14) begin
        n_checks++; if (inflight !== 4'd0 || busy !== 1'b0) begin n_errors++; $display("FAIL rr_inflight_drain: got %0d expected 0", inflight); end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_g, exp_rv;
    logic       exp_gt;
    set_op(1, two_v, two_v);
    set_op(3, one_v, two_v);
    for (int c = 0; c <= 14; c++) begin
      req = (c < 8) ? 4'b1010 : 4'b0000;
      if (c == 2) set_op(3, three_v, two_v);
      #1;
      exp_g  = (c < 8) ? ((c % 2 == 0) ? 4'b0010 : 4'b1000) : 4'h0;
      exp_rv = (c >= 6 && c <= 13) ? (((c - 6) % 2 == 0) ? 4'b0010 : 4'b1000) : 4'h0;
      exp_gt = (exp_rv == 4'b1000) && (c != 7);
      n_checks++; if (gnt !== exp_g) begin n_errors++; $display("FAIL b2b_gnt c=%0d: got %b expected %b", c, gnt, exp_g); end
      n_checks++; if (res_valid !== exp_rv) begin n_errors++; $display("FAIL b2b_res_valid c=%0d: got %b expected %b", c, res_valid, exp_rv); end
      if (exp_rv != 4'h0) begin
        n_checks++; if (res_gt !== exp_gt) begin n_errors++; $display("FAIL b2b_res_gt c=%0d: got %b expected %b", c, res_gt, exp_gt); end
      end
      if (c == 6 || c == 7) begin
        n_checks++; if (inflight !== 4'd6) begin n_errors++; $display("FAIL b2b_inflight c=%0d: got %0d expected 6", c, inflight); end
      end
      if (c == 14) begin
        n_checks++; if (inflight !== 4'd0) begin n_errors++; $display("FAIL b2b_inflight_drain: got %0d expected 0", inflight); end
      end
      tick();
    end
  endtask

  task automatic test_enable();
    logic [3:0] exp_g, exp_rv;
    set_op(1, one_v, two_v);
    set_op(2, two_v, one_v);
    req = 4'b0110;
    for (int c = 0; c <= 12; c++) begin
      en = (c >= 3 && c < 5);
      #1;
      exp_g  = (c == 3) ? 4'b0010 : (c == 4) ? 4'b0100 : 4'h0;
      exp_rv = (c == 9) ? 4'b0010 : (c == 10) ? 4'b0100 : 4'h0;
      n_checks++; if (gnt !== exp_g) begin n_errors++; $display("FAIL en_gnt c=%0d: got %b expected %b", c, gnt, exp_g); end
      n_checks++; if (cmp_vld !== (c == 4 || c == 5)) begin n_errors++; $display("FAIL en_cmp_vld c=%0d: got %b", c, cmp_vld); end
      n_checks++; if (res_valid !== exp_rv) begin n_errors++; $display("FAIL en_res_valid c=%0d: got %b expected %b", c, res_valid, exp_rv); end
      if (exp_rv != 4'h0) begin
        n_checks++; if (res_gt !== (c == 10)) begin n_errors++; $display("FAIL en_res_gt c=%0d: got %b expected %b", c, res_gt, (c == 10)); end
      end
      tick();
    end
    req = '0;
    en  = 1'b1;
  endtask

  task automatic test_reset_midflight();
    req = 4'hF;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (gnt !== 4'(1 << ((c + 3) % 4))) begin n_errors++; $display("FAIL rst_pre_gnt c=%0d: got %b", c, gnt); end
      tick();
    end
    req = '0;
    #1;
    n_checks++; if (inflight !== 4'd3) begin n_errors++; $display("FAIL rst_pre_inflight: got %0d expected 3", inflight); end
    req = 4'hF;
    rst = 1'b0;
    #1;
    n_checks++; if (gnt !== 4'h0 || cmp_vld !== 1'b0 || res_valid !== 4'h0) begin n_errors++; $display("FAIL rst_mid_ctrl: got gnt=%b vld=%b rv=%b expected 0", gnt, cmp_vld, res_valid); end
    n_checks++; if (inflight !== 4'd0 || busy !== 1'b0 || res_gt !== 1'b0) begin n_errors++; $display("FAIL rst_mid_state: got inflight=%0d busy=%b gt=%b expected 0", inflight, busy, res_gt); end
    n_checks++; if (cmp_a !== '0 || cmp_b !== '0) begin n_errors++; $display("FAIL rst_mid_cmp_ab: got %h/%h expected 0/0", cmp_a, cmp_b); end
    tick();
    req = '0;
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      n_checks++; if (res_valid !== 4'h0 || inflight !== 4'd0) begin n_errors++; $display("FAIL rst_post c=%0d: got rv=%b inflight=%0d expected 0", c, res_valid, inflight); end
      tick();
    end
  endtask

  initial begin
    one_v   = fp(1023, 52'h0);
    two_v   = fp(1024, 52'h0);
    three_v = fp(1024, 52'h8000000000000);
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_enable();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 Parameter WIDTH, 65, MSB index of one 11_52 operand word; each operand is WIDTH+1 = 66 bits.
REQ-002 Parameter NREQ, 4, number of requesters sharing the comparator; legal range 2..8.
REQ-003 Parameter LAT, 4, cycles from cmp_a/cmp_b presented to the matching cmp_gt; legal range 1..12.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req  input  NREQ  per-requester compare request, level, held until granted.
REQ-007 a_in  input  NREQ*(WIDTH+1)  operand A; requester i occupies bits [(i+1)*(WIDTH+1)-1 : i*(WIDTH+1)].
REQ-008 b_in  input  NREQ*(WIDTH+1)  operand B, same packing as a_in.
REQ-009 en  input  1  issue enable; low blocks new grants, in-flight operations still complete.
REQ-010 gnt  output  NREQ  one-hot or zero, combinational; operands of the granted requester are captured at the clock edge ending that cycle.
REQ-011 cmp_a  output  WIDTH+1  registered operand A to the shared comparator.
REQ-012 cmp_b  output  WIDTH+1  registered operand B to the shared comparator.
REQ-013 cmp_vld  output  1  registered; high while cmp_a/cmp_b carry an issued operation.
REQ-014 cmp_gt  input  1  comparator result (A > B) for operands presented LAT cycles earlier.
REQ-015 res_valid  output  NREQ  registered one-hot pulse; bit i marks a result for requester i.
REQ-016 res_gt  output  1  registered result bit, meaningful only while res_valid is nonzero.
REQ-017 inflight  output  4  number of issued operations whose res_valid pulse has not yet occurred.
REQ-018 busy  output  1  high when inflight is nonzero.

Function
REQ-019 Grant: when en=1 and req is nonzero, exactly one gnt bit is asserted: the first set req bit searching upward from index ptr, wrapping from NREQ-1 to 0.
REQ-020 gnt is zero when en=0, when req=0, or while rst is low.
REQ-021 ptr resets to 0; after a grant to requester i, ptr becomes (i+1) mod NREQ; ptr is unchanged in cycles without a grant.
REQ-022 Issue: on a grant in cycle 0, cmp_a/cmp_b load that requester's a_in/b_in slices and cmp_vld=1 in cycle 1; without a grant, cmp_vld=0 and cmp_a/cmp_b hold their values.
REQ-023 Tag pipeline: the requester index and valid bit travel alongside the comparator through LAT+1 stages; no other per-operation storage is used.
REQ-024 Result: an operation granted in cycle 0 produces res_valid[i]=1 and res_gt=cmp_gt (sampled in cycle 1+LAT) in cycle LAT+2, for exactly one cycle.
REQ-025 Throughput: one grant per cycle is sustained indefinitely; results return in grant order and never merge or drop.
REQ-026 res_valid=0 in every cycle with no completing tag; res_gt holds its previous value in those cycles.
REQ-027 inflight increments on a grant and decrements in each cycle with res_valid nonzero; both in the same cycle leaves it unchanged; the maximum value is LAT+2, and it never wraps.
REQ-028 A requester may re-request in the cycle after its grant; the request is arbitrated normally, so it cannot be granted twice in a row while another requester is waiting.
REQ-029 An en falling edge mid-stream stops new grants from that cycle on; tags already issued still emit res_valid on schedule.

Reset
REQ-030 While rst is low: gnt, cmp_vld, res_valid, res_gt, inflight, busy, ptr and all tag valids are 0, and cmp_a/cmp_b are 0.
REQ-031 Reset asserted mid-operation discards every in-flight operation; no res_valid pulse for a pre-reset grant appears after rst returns high.
REQ-032 The first grant is possible in the first cycle after rst deasserts.

Verification
REQ-033 Single request: LAT=4, req=4'b0001, a=2.0, b=1.0 at cycle 0 -> gnt=0001 in cycle 0; res_valid=0001, res_gt=1 in cycle 6; inflight returns to 0 in cycle 7.
REQ-034 Round-robin: req=4'b1111 held for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,... and res_valid follows the same order, LAT+2 cycles later.
REQ-035 Back-to-back mix: requesters 1 and 3 alternate, with equal operands on requester 1 (res_gt=0) and a<b on requester 3 (res_gt=0), then a>b (res_gt=1) -> each result reaches only its own res_valid bit; inflight peaks at LAT+2=6.
REQ-036 Enable gating: en=0 with req=4'b0110 -> gnt=0 and ptr unchanged; en=1 -> requester 1 granted first.
REQ-037 Reset mid-flight: 3 operations issued, rst low for 1 cycle at cycle 2 -> all outputs are 0 immediately, and no res_valid appears for 20 cycles after release without new requests.
